// File: rtl/txn_resp_pkg.sv
// ============================================================================
// txn_resp_pkg : shared types for the transaction responder
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package txn_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        DELAY    = 2'd1,
        ACK_HI   = 2'd2
    } hs_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NO_ARM   = 2'd1,
        ERR_NO_START = 2'd2,
        ERR_RESTART  = 2'd3
    } err_code_e;

    localparam int unsigned DLY_W = 4;

endpackage

`default_nettype wire

// File: rtl/hs4_ack_responder.sv
// ============================================================================
// hs4_ack_responder : 4-phase req/ack target with programmable ack delay
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module hs4_ack_responder
    import txn_resp_pkg::*;
#(
    parameter int unsigned ACK_DELAY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic req_i,
    output logic ack_o,
    output logic beat_o
);

    // DELAY spends ACK_DELAY cycles, so the counter starts one below it
    localparam logic [DLY_W-1:0] DLY_LOAD = (ACK_DELAY == 0) ? '0 : DLY_W'(ACK_DELAY - 1);

    hs_state_e        hs_state_q, hs_state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state_q <= WAIT_REQ;
            dly_q      <= '0;
            beat_q     <= 1'b0;
        end else begin
            hs_state_q <= hs_state_d;
            dly_q      <= dly_d;
            beat_q     <= beat_d;
        end
    end

    always_comb begin
        hs_state_d = hs_state_q;
        dly_d      = dly_q;
        beat_d     = 1'b0;
        case (hs_state_q)
            WAIT_REQ: begin
                if (req_i && enable_i) begin
                    if (ACK_DELAY == 0) begin
                        hs_state_d = ACK_HI;
                        beat_d     = 1'b1;
                    end else begin
                        hs_state_d = DELAY;
                        dly_d      = DLY_LOAD;
                    end
                end
            end
            // enable is not consulted past WAIT_REQ: a started handshake always completes
            DELAY: begin
                if (!req_i) begin
                    hs_state_d = WAIT_REQ;
                end else if (dly_q == '0) begin
                    hs_state_d = ACK_HI;
                    beat_d     = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ACK_HI: begin
                if (!req_i) begin
                    hs_state_d = WAIT_REQ;
                end
            end
            default: hs_state_d = WAIT_REQ;
        endcase
    end

    assign ack_o  = (hs_state_q == ACK_HI);
    assign beat_o = beat_q;

endmodule

`default_nettype wire

// File: rtl/txn_responder.sv
// ============================================================================
// txn_responder : transaction target - arm/frame FSM, beat counter, status,
//                 protocol error reporting and sticky interrupt
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module txn_responder
    import txn_resp_pkg::*;
#(
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ACK_DELAY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rt_i,
    input  logic             start_i,
    input  logic             endd_i,
    input  logic             stop_i,
    input  logic             req_i,
    output logic             ack_o,
    output logic             rdy_o,
    output logic             status_valid_o,
    output logic [LEN_W-1:0] status_len_o,
    output logic             status_aborted_o,
    output logic             er_o,
    output logic [1:0]       er_code_o,
    input  logic             irq_en_i,
    input  logic             irq_clr_i,
    output logic             interrupt_o
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             stat_vld_q, stat_vld_d;
    logic [LEN_W-1:0] stat_len_q, stat_len_d;
    logic             stat_abort_q, stat_abort_d;
    logic             er_q, er_d;
    err_code_e        er_code_q, er_code_d;
    logic             irq_q, irq_d;
    logic             hs_en;
    logic             beat;

    assign hs_en = (state_q == ACTIVE);

    hs4_ack_responder #(
        .ACK_DELAY (ACK_DELAY)
    ) u_hs (
        .clk      (clk),
        .rst      (rst),
        .enable_i (hs_en),
        .req_i    (req_i),
        .ack_o    (ack_o),
        .beat_o   (beat)
    );

    // includes a beat landing this cycle, so a close in the same cycle reports it
    assign cnt_inc = (beat && (cnt_q != CNT_MAX)) ? (cnt_q + LEN_W'(1)) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stat_vld_q   <= 1'b0;
            stat_len_q   <= '0;
            stat_abort_q <= 1'b0;
            er_q         <= 1'b0;
            er_code_q    <= ERR_NONE;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stat_vld_q   <= stat_vld_d;
            stat_len_q   <= stat_len_d;
            stat_abort_q <= stat_abort_d;
            er_q         <= er_d;
            er_code_q    <= er_code_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stat_vld_d   = 1'b0;
        stat_len_d   = '0;
        stat_abort_d = 1'b0;
        er_d         = 1'b0;
        er_code_d    = ERR_NONE;

        irq_d = irq_q;
        if (irq_clr_i) begin
            irq_d = 1'b0;
        end
        if ((stat_vld_q || er_q) && irq_en_i) begin
            irq_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    er_d      = 1'b1;
                    er_code_d = ERR_NO_ARM;
                end else if (endd_i || stop_i) begin
                    er_d      = 1'b1;
                    er_code_d = ERR_NO_START;
                end
                if (rt_i) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (endd_i || stop_i) begin
                    er_d      = 1'b1;
                    er_code_d = ERR_NO_START;
                end
                if (start_i) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                cnt_d = cnt_inc;
                if (start_i) begin
                    er_d      = 1'b1;
                    er_code_d = ERR_RESTART;
                end
                if (endd_i || stop_i) begin
                    state_d      = IDLE;
                    stat_vld_d   = 1'b1;
                    stat_len_d   = cnt_inc;
                    stat_abort_d = stop_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdy_o            = (state_q == ARMED);
    assign status_valid_o   = stat_vld_q;
    assign status_len_o     = stat_len_q;
    assign status_aborted_o = stat_abort_q;
    assign er_o             = er_q;
    assign er_code_o        = er_code_q;
    assign interrupt_o      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_txn_responder.sv
// ============================================================================
// tb_txn_responder : two responders (8-bit count / 2-cycle delay and
//                    2-bit count / no delay) driven in parallel
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_txn_responder;

    localparam int DLY_A = 2;
    localparam int DLY_B = 0;
    localparam int MAX_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rt_i = 1'b0, start_i = 1'b0, endd_i = 1'b0, stop_i = 1'b0, req_i = 1'b0;
    logic irq_en_i = 1'b0, irq_clr_i = 1'b0;

    logic       ack_a, rdy_a, sv_a, ab_a, er_a, int_a;
    logic [7:0] len_a;
    logic [1:0] ec_a;
    logic       ack_b, rdy_b, sv_b, ab_b, er_b, int_b;
    logic [1:0] len_b;
    logic [1:0] ec_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    txn_responder #(.LEN_W(8), .ACK_DELAY(DLY_A)) u_a (
        .clk(clk), .rst(rst), .rt_i(rt_i), .start_i(start_i), .endd_i(endd_i),
        .stop_i(stop_i), .req_i(req_i), .ack_o(ack_a), .rdy_o(rdy_a),
        .status_valid_o(sv_a), .status_len_o(len_a), .status_aborted_o(ab_a),
        .er_o(er_a), .er_code_o(ec_a), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
        .interrupt_o(int_a)
    );

    txn_responder #(.LEN_W(2), .ACK_DELAY(DLY_B)) u_b (
        .clk(clk), .rst(rst), .rt_i(rt_i), .start_i(start_i), .endd_i(endd_i),
        .stop_i(stop_i), .req_i(req_i), .ack_o(ack_b), .rdy_o(rdy_b),
        .status_valid_o(sv_b), .status_len_o(len_b), .status_aborted_o(ab_b),
        .er_o(er_b), .er_code_o(ec_b), .irq_en_i(irq_en_i), .irq_clr_i(irq_clr_i),
        .interrupt_o(int_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        rt_i = 1'b1; tick(); rt_i = 1'b0;
    endtask

    task automatic go();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    task automatic close(input bit e, input bit s);
        endd_i = e; stop_i = s; tick(); endd_i = 1'b0; stop_i = 1'b0;
    endtask

    // one full 4-phase beat; reports edges-to-ack for each DUT and any ack left high
    task automatic do_beat(output int ta, output int tb, output bit ack_left);
        ta = -1; tb = -1;
        req_i = 1'b1;
        for (int c = 1; c <= 20 && ta < 0; c++) begin
            tick();
            if (ack_a && ta < 0) ta = c;
            if (ack_b && tb < 0) tb = c;
        end
        req_i = 1'b0;
        tick();
        ack_left = ack_a | ack_b;
    endtask

    function automatic int min_b(input int n);
        return (n > MAX_B) ? MAX_B : n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({rdy_a, sv_a, er_a, ack_a, int_a, rdy_b, sv_b, er_b, ack_b, int_b} !== 10'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: got %b required 0", i,
                         {rdy_a, sv_a, er_a, ack_a, int_a, rdy_b, sv_b, er_b, ack_b, int_b});
            end
        end
    endtask

    task automatic test_basic();
        int ta, tb; bit left;
        arm();
        n_vec++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            n_err++; $display("FAIL basic_rdy_up: got %b required 11", {rdy_a, rdy_b});
        end
        tick();
        go();
        n_vec++;
        if ({rdy_a, rdy_b} !== 2'b00) begin
            n_err++; $display("FAIL basic_rdy_down: got %b required 00", {rdy_a, rdy_b});
        end
        for (int i = 0; i < 3; i++) begin
            do_beat(ta, tb, left);
            n_vec++;
            if (ta != DLY_A + 1 || tb != DLY_B + 1 || left) begin
                n_err++;
                $display("FAIL basic_beat%0d: got lat %0d/%0d ackleft %0b required %0d/%0d 0",
                         i, ta, tb, left, DLY_A + 1, DLY_B + 1);
            end
        end
        close(1'b1, 1'b0);
        n_vec++;
        if ({sv_a, sv_b, ab_a, ab_b, len_a, len_b} !== {2'b11, 2'b00, 8'd3, 2'd3}) begin
            n_err++;
            $display("FAIL basic_status: got v%b a%b len %0d/%0d required v11 a00 len 3/3",
                     {sv_a, sv_b}, {ab_a, ab_b}, len_a, len_b);
        end
        repeat (4) tick();
        n_vec++;
        if ({sv_a, sv_b, rdy_a, rdy_b} !== 4'b0) begin
            n_err++; $display("FAIL basic_after: got %b required 0000", {sv_a, sv_b, rdy_a, rdy_b});
        end
    endtask

    task automatic test_abort_irq();
        int ta, tb; bit left;
        irq_en_i = 1'b1;
        arm(); go();
        do_beat(ta, tb, left);
        close(1'b1, 1'b1);
        n_vec++;
        if ({sv_a, sv_b, ab_a, ab_b, len_a, len_b} !== {4'b1111, 8'd1, 2'd1}) begin
            n_err++;
            $display("FAIL abort_status: got v%b a%b len %0d/%0d required v11 a11 len 1/1",
                     {sv_a, sv_b}, {ab_a, ab_b}, len_a, len_b);
        end
        repeat (4) tick();
        n_vec++;
        if ({int_a, int_b} !== 2'b11) begin
            n_err++; $display("FAIL irq_sticky: got %b required 11", {int_a, int_b});
        end
        irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
        n_vec++;
        if ({int_a, int_b} !== 2'b00) begin
            n_err++; $display("FAIL irq_clear: got %b required 00", {int_a, int_b});
        end
        // clear coincides with an error pulse: the set must win
        go();
        irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
        n_vec++;
        if ({int_a, int_b} !== 2'b11) begin
            n_err++; $display("FAIL irq_set_wins: got %b required 11", {int_a, int_b});
        end
        irq_en_i = 1'b0;
        irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
    endtask

    task automatic test_errors();
        int ta, tb; bit left;
        go();
        n_vec++;
        if ({er_a, er_b, ec_a, ec_b} !== {2'b11, 2'd1, 2'd1}) begin
            n_err++; $display("FAIL err_no_arm: got %b required 110101", {er_a, er_b, ec_a, ec_b});
        end
        tick();
        n_vec++;
        if ({er_a, er_b, ec_a, ec_b} !== 6'b0) begin
            n_err++; $display("FAIL err_pulse_end: got %b required 0", {er_a, er_b, ec_a, ec_b});
        end
        arm();
        close(1'b1, 1'b0);
        n_vec++;
        if ({er_a, er_b, ec_a, ec_b, rdy_a, rdy_b, sv_a} !== {2'b11, 2'd2, 2'd2, 2'b11, 1'b0}) begin
            n_err++;
            $display("FAIL err_no_start: got %b required 111010110", {er_a, er_b, ec_a, ec_b, rdy_a, rdy_b, sv_a});
        end
        go();
        do_beat(ta, tb, left);
        go();
        n_vec++;
        if ({er_a, er_b, ec_a, ec_b, rdy_a} !== {2'b11, 2'd3, 2'd3, 1'b0}) begin
            n_err++; $display("FAIL err_restart: got %b required 1111110", {er_a, er_b, ec_a, ec_b, rdy_a});
        end
        do_beat(ta, tb, left);
        close(1'b1, 1'b0);
        n_vec++;
        if ({sv_a, len_a, sv_b, len_b} !== {1'b1, 8'd2, 1'b1, 2'd2}) begin
            n_err++; $display("FAIL restart_keeps_count: got len %0d/%0d required 2/2", len_a, len_b);
        end
        // start together with endd while active
        arm(); go();
        do_beat(ta, tb, left);
        start_i = 1'b1; endd_i = 1'b1; tick(); start_i = 1'b0; endd_i = 1'b0;
        n_vec++;
        if ({sv_a, ab_a, len_a, er_a, ec_a, sv_b, len_b, er_b, ec_b} !==
            {2'b10, 8'd1, 1'b1, 2'd3, 1'b1, 2'd1, 1'b1, 2'd3}) begin
            n_err++;
            $display("FAIL start_with_endd: got v%b len %0d/%0d er %b code %0d/%0d",
                     {sv_a, sv_b}, len_a, len_b, {er_a, er_b}, ec_a, ec_b);
        end
        tick();
    endtask

    task automatic test_saturate();
        int ta, tb; bit left; bit seen;
        arm();
        req_i = 1'b1;
        seen = 1'b0;
        repeat (6) begin tick(); seen |= ack_a | ack_b; end
        req_i = 1'b0;
        tick();
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL req_in_armed: got ack %b required 0", seen);
        end
        go();
        for (int i = 0; i < 5; i++) do_beat(ta, tb, left);
        close(1'b1, 1'b0);
        n_vec++;
        if ({sv_a, len_a, sv_b, len_b} !== {1'b1, 8'd5, 1'b1, 2'd3}) begin
            n_err++; $display("FAIL saturate: got len %0d/%0d required 5/3", len_a, len_b);
        end
        tick();
    endtask

    task automatic test_mid_exit();
        int ta;
        arm(); go();
        req_i = 1'b1; endd_i = 1'b1; tick(); endd_i = 1'b0;
        n_vec++;
        if ({sv_a, len_a, sv_b, len_b} !== {1'b1, 8'd0, 1'b1, 2'd0}) begin
            n_err++; $display("FAIL mid_exit_status: got len %0d/%0d required 0/0", len_a, len_b);
        end
        ta = ack_a ? 1 : -1;
        for (int c = 2; c <= 20 && ta < 0; c++) begin
            tick();
            if (ack_a) ta = c;
        end
        n_vec++;
        if (ta != DLY_A + 1 || ack_b !== 1'b1) begin
            n_err++; $display("FAIL mid_exit_completes: got lat %0d ackb %b required %0d 1", ta, ack_b, DLY_A + 1);
        end
        req_i = 1'b0; tick();
        n_vec++;
        if ({ack_a, ack_b} !== 2'b00) begin
            n_err++; $display("FAIL mid_exit_release: got %b required 00", {ack_a, ack_b});
        end
    endtask

    task automatic test_reset_mid();
        arm(); go();
        req_i = 1'b1;
        repeat (DLY_A + 1) tick();
        n_vec++;
        if ({ack_a, ack_b} !== 2'b11) begin
            n_err++; $display("FAIL rst_mid_pre: got %b required 11", {ack_a, ack_b});
        end
        rst = 1'b1; tick(); rst = 1'b0; req_i = 1'b0;
        n_vec++;
        if ({ack_a, rdy_a, sv_a, er_a, int_a, ack_b, rdy_b, sv_b, er_b, int_b} !== 10'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %b required 0",
                     {ack_a, rdy_a, sv_a, er_a, int_a, ack_b, rdy_b, sv_b, er_b, int_b});
        end
        repeat (3) tick();
        n_vec++;
        if ({rdy_a, rdy_b, sv_a, sv_b} !== 4'b0) begin
            n_err++; $display("FAIL rst_mid_idle: got %b required 0", {rdy_a, rdy_b, sv_a, sv_b});
        end
        arm();
        n_vec++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            n_err++; $display("FAIL rst_mid_rearm: got %b required 11", {rdy_a, rdy_b});
        end
        go(); close(1'b1, 1'b0); tick();
    endtask

    task automatic test_random();
        int ta, tb, n, kind; bit left, en, abrt;
        irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) tick();
            arm();
            repeat ($urandom_range(0, 3)) tick();
            go();
            n = $urandom_range(0, 6);
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                do_beat(ta, tb, left);
                n_vec++;
                if (ta != DLY_A + 1 || tb != DLY_B + 1 || left) begin
                    n_err++;
                    $display("FAIL rnd%0d_beat%0d: got lat %0d/%0d ackleft %0b required %0d/%0d 0",
                             it, b, ta, tb, left, DLY_A + 1, DLY_B + 1);
                end
            end
            kind = $urandom_range(0, 2);
            abrt = (kind != 0);
            en = 1'($urandom_range(0, 1));
            irq_en_i = en;
            close(kind != 1, kind != 0);
            n_vec++;
            if (sv_a !== 1'b1 || sv_b !== 1'b1 || ab_a !== abrt || ab_b !== abrt ||
                int'(len_a) != n || int'(len_b) != min_b(n)) begin
                n_err++;
                $display("FAIL rnd%0d_status: got v%b a%b len %0d/%0d required v11 a%0b len %0d/%0d",
                         it, {sv_a, sv_b}, {ab_a, ab_b}, len_a, len_b, abrt, n, min_b(n));
            end
            tick();
            n_vec++;
            if (int_a !== en || int_b !== en) begin
                n_err++; $display("FAIL rnd%0d_irq: got %b required %0b%0b", it, {int_a, int_b}, en, en);
            end
            irq_en_i = 1'b0;
            irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort_irq();
        test_errors();
        test_saturate();
        test_mid_exit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
